// File: rtl/phy_pkg.sv
// Shared definitions for the two-lane PHY transmit serializer: symbol defaults,
// training length and the transmit FSM encoding.
package phy_pkg;

    localparam logic [7:0] COM_BYTE_DEF  = 8'hBC;
    localparam logic [7:0] IDL_BYTE_DEF  = 8'h7C;
    localparam int         TRAIN_LEN_DEF = 4;
    localparam int         TRAIN_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_TRAIN   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SEND_HI = 2'd2,
        ST_SEND_LO = 2'd3
    } tx_state_e;

    function automatic logic is_payload(input tx_state_e s);
        return (s == ST_SEND_HI) || (s == ST_SEND_LO);
    endfunction

endpackage

// File: rtl/phy_tx_serializer_lane_shifter.sv
// One serial lane: 8-bit parallel-load shift register, MSB first, with a
// registered serial output so the loaded MSB appears the cycle after the load.
module lane_shifter (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       ser_o
);

    logic [7:0] sr_q;
    logic       ser_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q  <= 8'h00;
            ser_q <= 1'b0;
        end else if (load_i) begin
            ser_q <= byte_i[7];
            sr_q  <= {byte_i[6:0], 1'b0};
        end else begin
            ser_q <= sr_q[7];
            sr_q  <= {sr_q[6:0], 1'b0};
        end
    end

    assign ser_o = ser_q;

endmodule

// File: rtl/phy_tx_serializer.sv
// Two-lane serializer: stripes each accepted 32-bit word over two symbol slots,
// sending COM training after reset and IDL fill when no word is pending.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_TRAIN   | both lanes send COM_BYTE, TRAIN_LEN symbols after reset
// ST_IDLE    | both lanes send IDL_BYTE, waiting for a word
// ST_SEND_HI | lanes carry word[31:24] / word[23:16]
// ST_SEND_LO | lanes carry word[15:8]  / word[7:0]
module phy_tx_serializer
    import phy_pkg::*;
#(
    parameter logic [7:0] COM_BYTE  = COM_BYTE_DEF,
    parameter logic [7:0] IDL_BYTE  = IDL_BYTE_DEF,
    parameter int         TRAIN_LEN = TRAIN_LEN_DEF
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        data_out_0,
    output logic        data_out_1,
    output logic        tx_active
);

    tx_state_e              state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [TRAIN_CNT_W-1:0] train_cnt_q, train_cnt_d;
    logic [31:0]            hold_q, hold_d;
    logic                   started_q;
    logic                   boundary, train_done, xfer;
    logic [7:0]             lane0_byte, lane1_byte;

    assign boundary   = (bit_cnt_q == 3'd7);
    assign train_done = (train_cnt_q == TRAIN_CNT_W'(TRAIN_LEN - 1));
    assign xfer       = valid_in && ready_out;
    assign bit_cnt_d  = bit_cnt_q + 3'd1;
    assign hold_d     = xfer ? data_in : hold_q;

    // started_q marks the first boundary after reset, which only loads the
    // first COM symbol and must not advance training.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q     <= ST_TRAIN;
            bit_cnt_q   <= 3'd7;
            train_cnt_q <= '0;
            hold_q      <= 32'h0;
            started_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            train_cnt_q <= train_cnt_d;
            hold_q      <= hold_d;
            started_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        if (boundary && started_q) begin
            case (state_q)
                ST_TRAIN: begin
                    if (train_done) begin
                        state_d = xfer ? ST_SEND_HI : ST_IDLE;
                    end else begin
                        train_cnt_d = train_cnt_q + TRAIN_CNT_W'(1);
                    end
                end
                ST_IDLE:    state_d = xfer ? ST_SEND_HI : ST_IDLE;
                ST_SEND_HI: state_d = ST_SEND_LO;
                ST_SEND_LO: state_d = xfer ? ST_SEND_HI : ST_IDLE;
                default:    state_d = ST_TRAIN;
            endcase
        end
    end

    always_comb begin
        ready_out = !reset && started_q && boundary &&
                    ((state_q == ST_IDLE) || (state_q == ST_SEND_LO) ||
                     ((state_q == ST_TRAIN) && train_done));
        tx_active  = is_payload(state_q);
        lane0_byte = COM_BYTE;
        lane1_byte = COM_BYTE;
        case (state_d)
            ST_IDLE: begin
                lane0_byte = IDL_BYTE;
                lane1_byte = IDL_BYTE;
            end
            ST_SEND_HI: begin
                lane0_byte = hold_d[31:24];
                lane1_byte = hold_d[23:16];
            end
            ST_SEND_LO: begin
                lane0_byte = hold_d[15:8];
                lane1_byte = hold_d[7:0];
            end
            default: begin
                lane0_byte = COM_BYTE;
                lane1_byte = COM_BYTE;
            end
        endcase
    end

    lane_shifter u_lane0 (
        .clk_i   (clk_32f),
        .reset_i (reset),
        .load_i  (boundary),
        .byte_i  (lane0_byte),
        .ser_o   (data_out_0)
    );

    lane_shifter u_lane1 (
        .clk_i   (clk_32f),
        .reset_i (reset),
        .load_i  (boundary),
        .byte_i  (lane1_byte),
        .ser_o   (data_out_1)
    );

endmodule

// File: doc/phy_tx_serializer.md
PHY_TX_SERIALIZER -- requirements
Module: phy_tx_serializer

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk_32f (rising edge) and reset.
REQ-002 SHALL expose parameter COM_BYTE, default 8'hBC, training/comma symbol.
REQ-003 SHALL expose parameter IDL_BYTE, default 8'h7C, idle fill symbol.
REQ-004 SHALL expose parameter TRAIN_LEN, default 4, number of COM symbols sent after reset.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- clk_32f  in  1  bit clock.
- reset  in  1  sync active-high reset.
- data_in  in  32  word to transmit.
- valid_in  in  1  data_in valid.
- ready_out  out  1  word accepted this cycle if valid_in=1.
- data_out_0  out  1  serial lane 0.
- data_out_1  out  1  serial lane 1.
- tx_active  out  1  current symbol carries payload.

Function
REQ-006 SHALL count bit_cnt 0..7 per symbol slot; the edge with bit_cnt==7 is a symbol boundary, where bit_cnt wraps to 0 and both lane shift registers load the next byte.
REQ-007 SHALL drive data_out_x registered, MSB first: in the cycle with bit_cnt==k, the lane shows bit (7-k) of its current byte.
REQ-008 SHALL stripe each accepted word as follows:
- first symbol: lane0=data_in[31:24], lane1=data_in[23:16].
- second symbol: lane0=data_in[15:8], lane1=data_in[7:0].
REQ-009 SHALL implement FSM states TRAIN, IDLE, SEND_HI and SEND_LO, evaluated only at symbol boundaries:
- TRAIN: both lanes send COM_BYTE; after TRAIN_LEN symbols go to IDLE, or to SEND_HI on transfer.
- IDLE: both lanes send IDL_BYTE; go to SEND_HI on transfer.
- SEND_HI: always go to SEND_LO.
- SEND_LO: go to SEND_HI on transfer, else IDLE.
REQ-010 SHALL assert ready_out combinationally only when bit_cnt==7 and any of the following holds: state is IDLE; state is SEND_LO; state is TRAIN with train_cnt==TRAIN_LEN-1.
REQ-011 SHALL define a transfer as valid_in && ready_out; on transfer the word is captured in a 32-bit holding register.
REQ-012 SHALL hold data_in unaccepted while valid_in=1 and ready_out=0; upstream keeps data stable until transfer.
REQ-013 SHALL present bit 7 of data_in[31:24] in the cycle after the transfer edge (latency 1) and bit 0 of data_in[7:0] 16 cycles after it.
REQ-014 SHALL sustain back-to-back words with no idle gap (one word per 16 cycles).
REQ-015 SHALL assert tx_active exactly during cycles of SEND_HI/SEND_LO symbols.
REQ-016 SHALL saturate nothing: train_cnt counts 0..TRAIN_LEN-1 only in TRAIN, and is unused afterwards.

Reset
REQ-017 SHALL set the following while reset=1 at a clock edge:
- state=TRAIN, train_cnt=0, bit_cnt=7.
- shift registers 0, data_out_0=data_out_1=0, tx_active=0, ready_out=0.
REQ-018 SHALL treat the first edge with reset=0 as a symbol boundary loading COM_BYTE, so lanes show 1 (bit 7 of 8'hBC) in the next cycle.
REQ-019 SHALL, on reset mid-word, abandon the word (no completion) and restart training.

Structure
REQ-020 SHALL take COM_BYTE/IDL_BYTE defaults, TRAIN_LEN default and the FSM state encoding from shared package phy_pkg.
REQ-021 SHALL instantiate sub-module lane_shifter (8-bit parallel-load, MSB-first shift register with registered serial output) once per lane.

Verification
REQ-022 SHALL cover post-reset training: release reset, no valid -> each lane emits 10111100 four times, then 01111100 repeating; ready_out pulses only at bit_cnt==7 from the 4th COM symbol on.
REQ-023 SHALL cover a single word: data_in=32'hA1B2C3D4 held valid until transfer -> lane0 10100001 then 11000011, lane1 10110010 then 11010100, starting 1 cycle after transfer; tx_active high 16 cycles; then idle.
REQ-024 SHALL cover back-to-back transfer: 32'h11223344 then 32'h55667788 with valid held -> 32 contiguous payload cycles, second word's bit stream begins cycle 17, tx_active never drops.
REQ-025 SHALL cover stall: valid_in=1 with 32'hDEADBEEF asserted mid-symbol (bit_cnt=3) during IDLE -> no transfer until the bit_cnt==7 edge; remaining IDL bits unaffected.
REQ-026 SHALL cover reset mid-word: reset asserted at bit_cnt=4 of SEND_LO -> outputs 0 during reset; after release, COM training restarts and the abandoned word is never resumed.
